// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write-port arbiter.
//
// The execute (req0) and load (req1) writeback paths share a single
// register-file write port. When both are valid, a round-robin pointer picks
// the winner. The winning write is registered onto rf_we/rf_rd/rf_wd one
// cycle after the transfer.
//
// Ports:
//   clk, rst          sole clock (rising edge); synchronous active-high reset
//   hold              suspends all grants while high
//   req0_*            execute writeback: valid/rd/wd in, ready out
//   req1_*            load writeback:    valid/rd/wd in, ready out
//   rf_we/rf_rd/rf_wd registered write to the RegisterFile
//   grant_id          requester whose write is on rf_* this cycle
//   conflict_cnt      saturating count of cycles with both requests valid
//
// Optional feature (macro RF_ARB_BYPASS_EN):
//   rs1/rs2 in; byp1_hit/byp2_hit/byp1_data/byp2_data out.
//   These forward the write currently on rf_* to the matching read ports.
module rf_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_wd,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_wd,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        grant_id,
  output logic [7:0]  conflict_cnt
`ifdef RF_ARB_BYPASS_EN
  ,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        byp1_hit,
  output logic        byp2_hit,
  output logic [31:0] byp1_data,
  output logic [31:0] byp2_data
`endif
);

  typedef enum logic {PriReq0 = 1'b0, PriReq1 = 1'b1} pri_e;

  pri_e        pri_q, pri_d;
  logic        gnt0, gnt1;
  logic        xfer;
  logic [4:0]  win_rd;
  logic [31:0] win_wd;
  logic        both_valid;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;

  assign both_valid = req0_valid && req1_valid;

  // Grant selection and pointer update.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pri_d = pri_q;
    if (!rst && !hold) begin
      if (both_valid) begin
        if (pri_q == PriReq0) gnt0 = 1'b1;
        else                  gnt1 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    // Always prefer whoever did not just win; no grant leaves it alone.
    if (gnt0)      pri_d = PriReq1;
    else if (gnt1) pri_d = PriReq0;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 || gnt1;
  assign win_rd     = gnt1 ? req1_rd : req0_rd;
  assign win_wd     = gnt1 ? req1_wd : req0_wd;

  // Registered write-port state.
  always_comb begin
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      // x0 writes are accepted but never reach the register file.
      rf_we_d = (win_rd != 5'd0);
      rf_rd_d = win_rd;
      rf_wd_d = win_wd;
      grant_d = gnt1;
    end
    // Conflicts are counted even while hold suppresses the grant.
    if (both_valid && (cnt_q != 8'hff)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q   <= PriReq0;
      rf_we_q <= 1'b0;
      rf_rd_q <= 5'd0;
      rf_wd_q <= 32'd0;
      grant_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      pri_q   <= pri_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_rd        = rf_rd_q;
  assign rf_wd        = rf_wd_q;
  assign grant_id     = grant_q;
  assign conflict_cnt = cnt_q;

`ifdef RF_ARB_BYPASS_EN
  // Forward the in-flight write; masked during reset so no stale data leaks.
  assign byp1_hit  = !rst && rf_we_q && (rf_rd_q == rs1) && (rs1 != 5'd0);
  assign byp2_hit  = !rst && rf_we_q && (rf_rd_q == rs2) && (rs2 != 5'd0);
  assign byp1_data = byp1_hit ? rf_wd_q : 32'd0;
  assign byp2_data = byp2_hit ? rf_wd_q : 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand
// sequences for multi-cycle corners, then randomized traffic against a model.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_wd, req1_wd;
  logic        req0_ready, req1_ready;
  logic        rf_we, grant_id;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [7:0]  conflict_cnt;
`ifdef RF_ARB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .req0_valid   (req0_valid),
    .req0_rd      (req0_rd),
    .req0_wd      (req0_wd),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_rd      (req1_rd),
    .req1_wd      (req1_wd),
    .req1_ready   (req1_ready),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
`ifdef RF_ARB_BYPASS_EN
    ,
    .rs1          (rs1),
    .rs2          (rs2),
    .byp1_hit     (byp1_hit),
    .byp2_hit     (byp2_hit),
    .byp1_data    (byp1_data),
    .byp2_data    (byp2_data)
`endif
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] wd0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] wd1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_gid;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check ready mid-cycle, then
  // check registered outputs just after the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    rst        = v.rst;
    hold       = v.hold;
    req0_valid = v.v0;
    req0_rd    = v.rd0;
    req0_wd    = v.wd0;
    req1_valid = v.v1;
    req1_rd    = v.rd1;
    req1_wd    = v.wd1;
    #4;
    chk({tag, " req0_ready"}, req0_ready, v.e_r0);
    chk({tag, " req1_ready"}, req1_ready, v.e_r1);
    @(posedge clk);
    #1;
    chk({tag, " rf_we"}, rf_we, v.e_we);
    chk({tag, " rf_rd"}, rf_rd, v.e_rd);
    chk({tag, " rf_wd"}, rf_wd, v.e_wd);
    chk({tag, " grant_id"}, grant_id, v.e_gid);
    chk({tag, " conflict_cnt"}, conflict_cnt, v.e_cnt);
  endtask

  task automatic do_reset(input string tag);
    vec_t v;
    v = '{1'b1, 1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2,
          1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 8'd0};
    apply(v, tag);
  endtask

  // Reference model state for the random phase.
  int          m_pri, m_cnt, w;
  logic        m_we, m_gid;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        p0_v, p1_v;
  logic [4:0]  p0_rd, p1_rd;
  logic [31:0] p0_wd, p1_wd;

  initial begin
    vec_t v;
    rst = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_rd = '0; req0_wd = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_wd = '0;
`ifdef RF_ARB_BYPASS_EN
    rs1 = '0; rs2 = '0;
`endif
    do_reset("init_reset");

    //            rst   hold  v0   rd0    wd0           v1   rd1     wd1
    //            r0    r1    we   rd     wd            gid  cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b0, 1'b1, 1'b1, 5'd10, 32'hCAFEBABE, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b0, 8'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 8'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd3, 32'h4,
                 1'b0, 1'b1, 1'b1, 5'd3, 32'h4, 1'b1, 8'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 8'd3};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b0, 1'b0, 1'b0, 5'd3, 32'h3, 1'b0, 8'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b0, 1'b1, 1'b1, 5'd10, 32'hCAFEBABE, 1'b1, 8'd5};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd10, 32'hCAFEBABE,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b0, 8'd1};
    for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("row%0d", i));

    // Conflict straight out of reset: req0 then req1.
    do_reset("seq_a reset");
    v = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h0000AAAA, 1'b1, 5'd10, 32'hCAFEBABE,
          1'b1, 1'b0, 1'b1, 5'd5, 32'h0000AAAA, 1'b0, 8'd1};
    apply(v, "seq_a c1");
    v.e_r0 = 1'b0; v.e_r1 = 1'b1; v.e_rd = 5'd10; v.e_wd = 32'hCAFEBABE;
    v.e_gid = 1'b1; v.e_cnt = 8'd2;
    apply(v, "seq_a c2");

    // Hold for 3 cycles, then grant resumes with req0 preferred.
    do_reset("seq_b reset");
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'd10, 32'hA,
            1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'(i + 1)};
      apply(v, $sformatf("seq_b hold%0d", i));
    end
    v = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd10, 32'hA,
          1'b1, 1'b0, 1'b1, 5'd5, 32'h5, 1'b0, 8'd4};
    apply(v, "seq_b resume");

    // Saturation over 300 held conflict cycles, then reset clears it.
    do_reset("seq_c reset");
    for (int i = 0; i < 300; i++) begin
      v = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'd10, 32'hA,
            1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 8'((i + 1 > 255) ? 255 : i + 1)};
      apply(v, $sformatf("seq_c hold%0d", i));
    end
    do_reset("seq_c rst");
    v = '{1'b0, 1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd10, 32'hA,
          1'b1, 1'b0, 1'b1, 5'd5, 32'h5, 1'b0, 8'd1};
    apply(v, "seq_c after");

`ifdef RF_ARB_BYPASS_EN
    v = '{1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 8'd1};
    apply(v, "byp write");
    req0_valid = 1'b0;
    rs1 = 5'd7; rs2 = 5'd0;
    #1;
    chk("byp1_hit", byp1_hit, 1'b1);
    chk("byp1_data", byp1_data, 32'h12345678);
    chk("byp2_hit", byp2_hit, 1'b0);
    chk("byp2_data", byp2_data, 32'h0);
    @(posedge clk);
    #1;
    rs1 = '0;
`endif

    // Randomized traffic against the model.
    do_reset("rand reset");
    m_pri = 0; m_cnt = 0; m_we = 0; m_rd = 0; m_wd = 0; m_gid = 0;
    p0_v = 0; p1_v = 0; p0_rd = 0; p1_rd = 0; p0_wd = 0; p1_wd = 0;
    for (int c = 0; c < 800; c++) begin
      // Requesters keep a pending request stable until it is accepted.
      if (!p0_v && ($urandom_range(0, 2) != 0)) begin
        p0_v  = 1'b1;
        p0_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p0_wd = $urandom;
      end
      if (!p1_v && ($urandom_range(0, 2) != 0)) begin
        p1_v  = 1'b1;
        p1_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p1_wd = $urandom;
      end
      rst        = ($urandom_range(0, 39) == 0);
      hold       = ($urandom_range(0, 5) == 0);
      req0_valid = p0_v; req0_rd = p0_rd; req0_wd = p0_wd;
      req1_valid = p1_v; req1_rd = p1_rd; req1_wd = p1_wd;

      if (rst || hold)        w = -1;
      else if (p0_v && p1_v)  w = m_pri;
      else if (p0_v)          w = 0;
      else if (p1_v)          w = 1;
      else                    w = -1;

      #4;
      chk($sformatf("rand%0d req0_ready", c), req0_ready, (w == 0));
      chk($sformatf("rand%0d req1_ready", c), req1_ready, (w == 1));
      @(posedge clk);
      #1;

      if (rst) begin
        m_pri = 0; m_cnt = 0; m_we = 0; m_rd = 0; m_wd = 0; m_gid = 0;
      end else begin
        if (p0_v && p1_v && m_cnt < 255) m_cnt++;
        if (w < 0) begin
          m_we = 1'b0;
        end else begin
          m_rd  = (w == 0) ? p0_rd : p1_rd;
          m_wd  = (w == 0) ? p0_wd : p1_wd;
          m_we  = (m_rd != 5'd0);
          m_gid = (w == 1);
          m_pri = 1 - w;
          if (w == 0) p0_v = 1'b0;
          else        p1_v = 1'b0;
        end
      end
      chk($sformatf("rand%0d rf_we", c), rf_we, m_we);
      chk($sformatf("rand%0d rf_rd", c), rf_rd, m_rd);
      chk($sformatf("rand%0d rf_wd", c), rf_wd, m_wd);
      chk($sformatf("rand%0d grant_id", c), grant_id, m_gid);
      chk($sformatf("rand%0d conflict_cnt", c), conflict_cnt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: hold  in  1  suspends all grants while high.
REQ-004 SHALL have ports: req0_valid in 1, req0_rd in 5, req0_wd in 32, req0_ready out 1  (execute writeback requester).
REQ-005 SHALL have ports: req1_valid in 1, req1_rd in 5, req1_wd in 32, req1_ready out 1  (load writeback requester).
REQ-006 SHALL have ports: rf_we out 1, rf_rd out 5, rf_wd out 32  (drive RegisterFile we/rd/wd).
REQ-007 SHALL have ports: grant_id  out  1  requester whose write is on rf_* this cycle.
REQ-008 SHALL have ports: conflict_cnt  out  8  saturating count of cycles with both requests valid.
REQ-009 SHALL, under RF_ARB_BYPASS_EN only, have ports: rs1 in 5, rs2 in 5, byp1_hit out 1, byp2_hit out 1, byp1_data out 32, byp2_data out 32.

Function
REQ-010 SHALL define transfer on reqN as reqN_valid && reqN_ready at a rising clk edge; requesters hold valid/rd/wd stable until ready.
REQ-011 SHALL drive reqN_ready combinationally, at most one ready high per cycle, both low when hold or rst is high.
REQ-012 SHALL hold a 1-bit priority pointer with states PRI0 (req0 preferred) and PRI1 (req1 preferred).
REQ-013 SHALL grant the only valid requester when one is valid, regardless of pointer.
REQ-014 SHALL grant the preferred requester when both are valid, then move the pointer to prefer the other.
REQ-015 SHALL, on any single grant, set pointer to prefer the non-granted requester; pointer unchanged when no grant.
REQ-016 SHALL register the winner: cycle after transfer, rf_we=1, rf_rd/rf_wd=winner's rd/wd, grant_id=winner; latency exactly 1 cycle.
REQ-017 SHALL drive rf_we=0 in cycles following no transfer; rf_rd, rf_wd, grant_id hold last values.
REQ-018 SHALL accept (ready high) a request with rd=0 but drive rf_we=0 next cycle; pointer still updates.
REQ-019 SHALL arbitrate requests targeting the same rd normally; the later-granted value is written last and wins.
REQ-020 SHALL increment conflict_cnt each cycle both valids are high and rst is low (hold included), saturating at 255.
REQ-021 SHALL sustain one grant per cycle; back-to-back grants from one requester are allowed when the other is idle.

Reset
REQ-022 SHALL, on a cycle with rst high, set next-cycle rf_we=0, rf_rd=0, rf_wd=0, grant_id=0, conflict_cnt=0, pointer=PRI0.
REQ-023 SHALL accept no request in a rst cycle; a write registered before rst is overwritten by reset values (it is still applied to the register file that edge is not guaranteed).
REQ-024 SHALL drive byp1_hit=byp2_hit=0 and byp1_data=byp2_data=0 during and after reset until the next registered write.

Configuration
REQ-025 SHALL use macro RF_ARB_BYPASS_EN to compile in the read bypass.
REQ-026 SHALL, with RF_ARB_BYPASS_EN defined, set bypN_hit = rf_we && rf_rd==rsN && rsN!=0, combinationally; bypN_data = rf_wd when hit, else 0.
REQ-027 SHALL, without RF_ARB_BYPASS_EN, omit rs1, rs2 and all byp* ports; arbitration behaviour identical.

Verification
REQ-028 SHALL test: req0 only, rd=5, wd=DEADBEEF -> req0_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wd=DEADBEEF, grant_id=0.
REQ-029 SHALL test: after reset both valid (req0 rd=5, req1 rd=10 CAFEBABE) held 2 cycles -> grants req0 then req1; conflict_cnt=1 after first cycle, rf_rd=5 then 10.
REQ-030 SHALL test: req0 rd=0 wd=FFFFFFFF -> req0_ready=1, next cycle rf_we=0; pointer now PRI1.
REQ-031 SHALL test: hold=1 with both valid 3 cycles -> both ready 0, rf_we=0, conflict_cnt=3; hold=0 -> grant resumes with PRI0.
REQ-032 SHALL test: conflict held 300 cycles with hold=1 -> conflict_cnt=255; then rst 1 cycle -> all outputs 0, req0 wins next conflict.
REQ-033 SHALL test (RF_ARB_BYPASS_EN): rf_we=1 rf_rd=7 rf_wd=12345678, rs1=7, rs2=0 -> byp1_hit=1, byp1_data=12345678, byp2_hit=0, byp2_data=0.
